// File: rtl/msrv32_iadder_arbiter.sv
// rtl/msrv32_iadder_arbiter.sv - shared immediate adder with round-robin arbitration
//
// Purpose: one XLEN-bit (base + imm) adder shared by the control-transfer
// unit (port 0) and the load/store unit (port 1). The result, its owner and
// the control-transfer misalignment flag sit in a single-entry output
// register until the consumer takes them.
//
// Ports:
//   clk_in, rst_in                      clock, async active-low reset
//   req0_valid_in / req0_ready_out      port 0 handshake
//   req0_src_in, req0_jalr_in           base select (0 pc, 1 rs1), clear bit 0
//   req0_pc_in, req0_rs_1_in, req0_imm_in  port 0 operands
//   req1_valid_in / req1_ready_out      port 1 handshake
//   req1_src_in                         base select
//   req1_pc_in, req1_rs_1_in, req1_imm_in  port 1 operands
//   out_valid_out / out_ready_in        result handshake
//   iadder_out, owner_out, misaligned_out  registered result fields
//   conflict_cnt_out                    saturating count of both-valid cycles
module msrv32_iadder_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req0_valid_in,
  output logic             req0_ready_out,
  input  logic             req0_src_in,
  input  logic             req0_jalr_in,
  input  logic [XLEN-1:0]  req0_pc_in,
  input  logic [XLEN-1:0]  req0_rs_1_in,
  input  logic [XLEN-1:0]  req0_imm_in,
  input  logic             req1_valid_in,
  output logic             req1_ready_out,
  input  logic             req1_src_in,
  input  logic [XLEN-1:0]  req1_pc_in,
  input  logic [XLEN-1:0]  req1_rs_1_in,
  input  logic [XLEN-1:0]  req1_imm_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [XLEN-1:0]  iadder_out,
  output logic             owner_out,
  output logic             misaligned_out,
  output logic [CNT_W-1:0] conflict_cnt_out
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic             rr_q;      // requester preferred when both are valid
  logic [XLEN-1:0]  sum_q;
  logic             owner_q;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q;

  logic             can_accept;
  logic             both_valid;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [XLEN-1:0]  base0;
  logic [XLEN-1:0]  base1;
  logic [XLEN-1:0]  raw0;
  logic [XLEN-1:0]  sum0;
  logic [XLEN-1:0]  sum1;
  logic [XLEN-1:0]  sum_sel;
  logic             mis_sel;

  assign can_accept = (state_q == S_EMPTY) || out_ready_in;
  assign both_valid = req0_valid_in && req1_valid_in;

  assign grant0 = req0_valid_in && (!req1_valid_in || !rr_q);
  assign grant1 = req1_valid_in && (!req0_valid_in ||  rr_q);

  // rst_in gates the readies so nothing is offered while reset is held,
  // even though the EMPTY state alone would allow an accept.
  assign req0_ready_out = grant0 && can_accept && rst_in;
  assign req1_ready_out = grant1 && can_accept && rst_in;
  assign accept         = req0_ready_out || req1_ready_out;

  assign base0 = req0_src_in ? req0_rs_1_in : req0_pc_in;
  assign base1 = req1_src_in ? req1_rs_1_in : req1_pc_in;
  assign raw0  = base0 + req0_imm_in;
  assign sum0  = {raw0[XLEN-1:1], raw0[0] & ~req0_jalr_in};
  assign sum1  = base1 + req1_imm_in;

  assign sum_sel = grant1 ? sum1 : sum0;
  // Misalignment is only meaningful for control-transfer targets.
  assign mis_sel = !grant1 && sum0[1];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_EMPTY;
      rr_q    <= 1'b0;
      sum_q   <= '0;
      owner_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (both_valid && !(&cnt_q)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (accept) begin
        sum_q   <= sum_sel;
        owner_q <= grant1;
        mis_q   <= mis_sel;
        rr_q    <= !grant1;
      end

      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_q <= S_FULL;
          end
        end
        S_FULL: begin
          if (!accept && out_ready_in) begin
            state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign out_valid_out    = (state_q == S_FULL);
  assign iadder_out       = sum_q;
  assign owner_out        = owner_q;
  assign misaligned_out   = mis_q;
  assign conflict_cnt_out = cnt_q;

endmodule
